pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined CPU, the successor to the single-register PC. It holds the fetch PC, selects the next PC from exception, branch, jump, return-prediction and sequential sources with fixed priority, honours a hazard-unit write enable, and contains a small return-address stack (RAS) that predicts `jr $ra` targets. It sits at the front of the IF stage, feeding instruction memory and the IF/ID pipeline register.

## Interface
- `PC_W`, 32: PC width in bits.
- `RESET_VEC`, 0: PC value after reset.
- `EXC_VEC`, 32'h0000_0080: exception handler address, truncated to `PC_W`.
- `RAS_DEPTH`, 4: RAS entries; a power of two, at least 2.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `pc_write_i`  in  1  1 = PC may advance; 0 = hold (load-use stall).
- `exc_i`  in  1  exception redirect to `EXC_VEC`.
- `branch_taken_i`  in  1  resolved taken branch.
- `branch_target_i`  in  PC_W  branch target.
- `jump_i`  in  1  jump redirect.
- `jump_target_i`  in  PC_W  jump target.
- `ret_i`  in  1  return: predict target from RAS top.
- `push_i`  in  1  call seen; push `push_data_i`.
- `push_data_i`  in  PC_W  link address to push.
- `pc_o`  out  PC_W  current fetch PC.
- `pc_plus4_o`  out  PC_W  `pc_o + 4`, modulo 2^PC_W.
- `ras_empty_o`  out  1  RAS count is 0.
- `ras_full_o`  out  1  RAS count equals `RAS_DEPTH`.
- `ret_miss_o`  out  1  registered one-cycle pulse: a committed return found the RAS empty.

## Operation
- Commit condition: `commit = pc_write_i | exc_i`. The exception overrides a stall.
- Next-PC priority (highest first):
  - `exc_i` → `EXC_VEC`.
  - `branch_taken_i` → `branch_target_i`.
  - `jump_i` → `jump_target_i`.
  - `ret_i` with RAS non-empty → RAS top.
  - `ret_i` with RAS empty → `pc_o + 4`, and `ret_miss_o` pulses.
  - Otherwise → `pc_o + 4`.
- All additions wrap modulo 2^PC_W; no overflow flag.
- RAS updates happen only on a commit cycle. With `commit = 0`, all push/pop requests are dropped.
- Pop occurs only when the return source actually wins selection and the RAS is non-empty.
- Push occurs when `push_i = 1`, independent of which source is selected.
- Pop and push in the same cycle: the top entry is overwritten with `push_data_i`; count is unchanged.
- Push when full: circular overwrite of the oldest entry; count stays at `RAS_DEPTH`; top pointer advances.
- Pop when empty: no pointer or count change.
- A committed `exc_i` clears the RAS (count = 0) and ignores `push_i` in that cycle.
- The RAS is a circular buffer: top pointer of `log2(RAS_DEPTH)` bits, count of `log2(RAS_DEPTH)+1` bits.

## Timing
- Reset, asynchronous: `pc_o = RESET_VEC`, RAS count and pointer = 0, `ret_miss_o = 0`, `ras_empty_o = 1`, `ras_full_o = 0`. Reset mid-operation abandons any pending redirect or push immediately.
- First rising edge after reset release with `pc_write_i = 1`: `pc_o` becomes `RESET_VEC + 4`.
- Redirect latency is one cycle: inputs sampled at edge N appear on `pc_o` after edge N.
- `pc_plus4_o` is combinational from `pc_o`.
- `ras_empty_o` and `ras_full_o` are combinational from the count and reflect post-edge state.
- `ret_miss_o` is registered: high for exactly the cycle following the missed return.
- Redirect inputs are level-sampled each cycle; there is no handshake.

## Structure
- Shared package `pc_pkg`:
  - `pc_sel_e` = {`SEL_SEQ`, `SEL_RET`, `SEL_JUMP`, `SEL_BRANCH`, `SEL_EXC`}.
  - Constant `PC_INC = 4`.
- Sub-module `ras_stack`, parametrised by `W` and `DEPTH`:
  - Inputs: push, pop, clear, data.
  - Outputs: top, empty, full.
- `pc_unit` contains the priority select, commit gating, PC register, and miss-pulse register.

## Test plan
- Reset then 3 free-running cycles → `pc_o` = 0, 4, 8, 12. Assert `rst_i` low mid-cycle → `pc_o` = 0 immediately.
- `pc_write_i = 0` for 2 cycles at `pc_o = 0x10` with `jump_i = 1` → `pc_o` holds 0x10. Same stall with `exc_i = 1` → `pc_o = 0x80`.
- Same cycle: `branch_taken_i` (target 0x200), `jump_i` (target 0x300), `ret_i` → `pc_o = 0x200`; RAS count unchanged.
- `RAS_DEPTH = 4`; push 0x100, 0x104, 0x108, 0x10C, 0x110 → `ras_full_o = 1`. Then 4 returns → `pc_o` = 0x110, 0x10C, 0x108, 0x104, then `ras_empty_o = 1`.
- `ret_i` with RAS empty at `pc_o = 0x40` → `pc_o = 0x44`; `ret_miss_o` high for exactly one cycle.
- `pc_o = 0xFFFF_FFFC`, sequential step → `pc_o = 0`. Push and return in the same cycle with top = 0x500 and `push_data_i = 0x600` → `pc_o = 0x500`; new top = 0x600.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// Next-PC source select and the sequential increment.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_RET    = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_EXC    = 3'd4
    } pc_sel_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
// A push when full overwrites the oldest entry; pop+push overwrites the top.
module ras_stack
    import pc_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_do_pop;
    logic          w_do_push;
    logic [PW-1:0] w_wr_idx;

    assign empty_o   = (r_cnt == '0);
    assign full_o    = (r_cnt == FULL_CNT);
    assign top_o     = r_mem[r_ptr];
    assign w_do_pop  = pop_i & ~empty_o & ~clear_i;
    assign w_do_push = push_i & ~clear_i;
    assign w_wr_idx  = w_do_pop ? r_ptr : r_ptr + 1'b1;

    // Entry storage: written on push, into the top slot or the next one.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= data_i;
        end
    end

    // Top pointer and occupancy count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_do_pop && !w_do_push) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end else if (w_do_push && !w_do_pop) begin
            r_ptr <= r_ptr + 1'b1;
            if (!full_o) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised next-PC select
// and a return-address stack predicting return targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [31:0]     EXC_VEC   = 32'h0000_0080,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            exc_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            ret_i,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ret_miss_o
);

    localparam logic [PC_W-1:0] EXC_ADDR = PC_W'(EXC_VEC);
    localparam logic [PC_W-1:0] INC      = PC_W'(PC_INC);

    logic [PC_W-1:0] r_pc;
    logic            r_miss;

    pc_sel_e         w_sel;
    logic [PC_W-1:0] w_next;
    logic [PC_W-1:0] w_ras_top;
    logic            w_commit;
    logic            w_ret_sel;
    logic            w_pop;
    logic            w_push;
    logic            w_clear;
    logic            w_miss;

    assign w_commit   = pc_write_i | exc_i;
    assign w_ret_sel  = (w_sel == SEL_RET);
    assign w_pop      = w_commit & w_ret_sel & ~ras_empty_o;
    assign w_miss     = w_commit & w_ret_sel & ras_empty_o;
    assign w_push     = w_commit & push_i & ~exc_i;
    assign w_clear    = exc_i;
    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc + INC;
    assign ret_miss_o = r_miss;

    // Fixed-priority source select.
    always_comb begin
        w_sel = SEL_SEQ;
        if (exc_i) begin
            w_sel = SEL_EXC;
        end else if (branch_taken_i) begin
            w_sel = SEL_BRANCH;
        end else if (jump_i) begin
            w_sel = SEL_JUMP;
        end else if (ret_i) begin
            w_sel = SEL_RET;
        end
    end

    // Next-PC mux; a return with an empty stack falls through to pc+4.
    always_comb begin
        w_next = pc_plus4_o;
        unique case (w_sel)
            SEL_EXC:    w_next = EXC_ADDR;
            SEL_BRANCH: w_next = branch_target_i;
            SEL_JUMP:   w_next = jump_target_i;
            SEL_RET:    w_next = ras_empty_o ? pc_plus4_o : w_ras_top;
            default:    w_next = pc_plus4_o;
        endcase
    end

    // PC register; holds when the hazard unit stalls and no exception.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc <= RESET_VEC;
        end else if (w_commit) begin
            r_pc <= w_next;
        end
    end

    // One-cycle pulse after a committed return that found the stack empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_miss <= 1'b0;
        end else begin
            r_miss <= w_miss;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clear_i (w_clear),
        .data_i  (push_data_i),
        .top_o   (w_ras_top),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus, queue-based reference model,
// per-cycle output comparison plus literal spot checks.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pw = 1'b0;
    logic        exc = 1'b0;
    logic        br = 1'b0;
    logic [31:0] bt = '0;
    logic        jmp = 1'b0;
    logic [31:0] jt = '0;
    logic        ret = 1'b0;
    logic        push = 1'b0;
    logic [31:0] pd = '0;

    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        ras_empty_o;
    logic        ras_full_o;
    logic        ret_miss_o;

    int compared = 0;
    int mismatched = 0;

    pc_unit #(
        .PC_W      (32),
        .RESET_VEC (32'h0),
        .EXC_VEC   (32'h80),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .pc_write_i      (pw),
        .exc_i           (exc),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jmp),
        .jump_target_i   (jt),
        .ret_i           (ret),
        .push_i          (push),
        .push_data_i     (pd),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o),
        .ret_miss_o      (ret_miss_o)
    );

    initial forever #5 clk = ~clk;

    // Reference model: a PC value, a bounded stack and a miss flag.
    logic [31:0] m_pc = '0;
    logic [31:0] m_stk[$];
    logic        m_miss = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            m_stk.delete();
            m_miss = 1'b0;
        end else begin
            m_miss = 1'b0;
            if (pw || exc) begin
                if (exc) begin
                    m_pc = 32'h80;
                    m_stk.delete();
                end else begin
                    if (br) m_pc = bt;
                    else if (jmp) m_pc = jt;
                    else if (ret && m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        if (ret) m_miss = 1'b1;
                        m_pc = m_pc + 32'd4;
                    end
                    if (push) begin
                        m_stk.push_back(pd);
                        if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pc", pc_o, m_pc);
        chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("empty", 32'(ras_empty_o), 32'(m_stk.size() == 0));
        chk("full", 32'(ras_full_o), 32'(m_stk.size() == DEPTH));
        chk("miss", 32'(ret_miss_o), 32'(m_miss));
    end

    task automatic idle();
        pw = 0; exc = 0; br = 0; jmp = 0; ret = 0; push = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_step();
        idle(); pw = 1; tick();
    endtask

    task automatic jump_to(input logic [31:0] a);
        idle(); pw = 1; jmp = 1; jt = a; tick();
    endtask

    task automatic push_step(input logic [31:0] d);
        idle(); pw = 1; push = 1; pd = d; tick();
    endtask

    task automatic ret_step();
        idle(); pw = 1; ret = 1; tick();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_empty", 32'(ras_empty_o), 32'd1);
        chk("rst_full", 32'(ras_full_o), 32'd0);
        chk("rst_miss", 32'(ret_miss_o), 32'd0);
        rst_n = 1'b1;

        seq_step(); chk("seq1", pc_o, 32'h4);
        seq_step(); chk("seq2", pc_o, 32'h8);
        seq_step(); chk("seq3", pc_o, 32'hC);
        #2 rst_n = 1'b0;
        #1 chk("midrst", pc_o, 32'h0);
        rst_n = 1'b1;

        repeat (4) seq_step();
        chk("at10", pc_o, 32'h10);
        idle(); jmp = 1; jt = 32'h300;
        tick(); tick();
        chk("stall", pc_o, 32'h10);
        idle(); exc = 1;
        tick();
        chk("exc_stall", pc_o, 32'h80);

        push_step(32'h900);
        idle(); pw = 1; br = 1; bt = 32'h200; jmp = 1; jt = 32'h300; ret = 1;
        tick();
        chk("prio", pc_o, 32'h200);
        chk("prio_ras", 32'(ras_empty_o), 32'd0);

        push_step(32'h100);
        push_step(32'h104);
        push_step(32'h108);
        push_step(32'h10C);
        push_step(32'h110);
        chk("full", 32'(ras_full_o), 32'd1);
        ret_step(); chk("r1", pc_o, 32'h110);
        ret_step(); chk("r2", pc_o, 32'h10C);
        ret_step(); chk("r3", pc_o, 32'h108);
        ret_step(); chk("r4", pc_o, 32'h104);
        chk("drained", 32'(ras_empty_o), 32'd1);

        jump_to(32'h40);
        ret_step();
        chk("miss_pc", pc_o, 32'h44);
        chk("miss_hi", 32'(ret_miss_o), 32'd1);
        seq_step();
        chk("miss_lo", 32'(ret_miss_o), 32'd0);

        jump_to(32'hFFFF_FFFC);
        chk("p4wrap", pc_plus4_o, 32'h0);
        seq_step();
        chk("wrap", pc_o, 32'h0);

        push_step(32'h500);
        idle(); pw = 1; ret = 1; push = 1; pd = 32'h600;
        tick();
        chk("pp_pc", pc_o, 32'h500);
        ret_step();
        chk("pp_top", pc_o, 32'h600);
        chk("pp_empty", 32'(ras_empty_o), 32'd1);

        push_step(32'h700);
        idle(); pw = 1; exc = 1; push = 1; pd = 32'h800;
        tick();
        chk("exc_clr", 32'(ras_empty_o), 32'd1);
        chk("exc_pc", pc_o, 32'h80);

        idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
